// File: rtl/fft_core_param.sv
// fft_core_param -- iterative radix-2 decimation-in-time FFT/IFFT engine.
//
// Frame flow: LOAD (N input beats) -> CALC (LOG2N*N/2 butterfly cycles)
// -> UNLOAD (N output bins in natural order). Only one frame is in flight.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   in_valid/in_ready input handshake; in_r/in_i complex sample (DW bits)
//   tw_r/tw_i         twiddle W_N^k for beat k, captured on beats 0..N/2-1
//   inv               inverse-transform select, captured on beat 0
//   out_valid/ready   output handshake; out_r/out_i complex bin (OW bits)
//   out_idx/out_last  bin index, high on bin N-1
//   state             0 = LOAD, 1 = CALC, 2 = UNLOAD
//   done              one-cycle pulse after the out_last handshake
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A valid source holds its data stable
// until that edge; ready may change freely and never depends on valid.
module fft_core_param #(
    parameter int LOG2N = 3,
    parameter int DW    = 8,
    parameter int TW    = 10,
    parameter int OW    = DW + 2 * LOG2N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_r,
    input  logic signed [DW-1:0]   in_i,
    input  logic signed [TW-1:0]   tw_r,
    input  logic signed [TW-1:0]   tw_i,
    input  logic                   inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OW-1:0]   out_r,
    output logic signed [OW-1:0]   out_i,
    output logic [LOG2N-1:0]       out_idx,
    output logic                   out_last,
    output logic [1:0]             state,
    output logic                   done
);

    localparam int N  = 1 << LOG2N;
    localparam int NH = N / 2;
    localparam int SW = $clog2(LOG2N);
    localparam int PW = OW + TW + 2;   // room for a full complex product sum

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_CALC   = 2'd1,
        S_UNLOAD = 2'd2
    } state_t;

    state_t                  r_state;
    logic [LOG2N-1:0]        r_cnt;        // input beat counter
    logic [SW-1:0]           r_stage;      // butterfly stage
    logic [LOG2N-2:0]        r_bf;         // butterfly index within stage
    logic [LOG2N-1:0]        r_out_idx;
    logic                    r_out_valid;
    logic                    r_done;
    logic                    r_inv;

    logic signed [OW-1:0]    r_buf_r [N];
    logic signed [OW-1:0]    r_buf_i [N];
    logic signed [TW-1:0]    r_tw_r  [NH];
    logic signed [TW-1:0]    r_tw_i  [NH];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int k = 0; k < LOG2N; k++) begin
            r[k] = v[LOG2N-1-k];
        end
        return r;
    endfunction

    // Butterfly addressing: a is the butterfly index with a 0 inserted at
    // bit position 'stage', so pairs come out in ascending order of a.
    logic [LOG2N-1:0]        w_j;
    logic [LOG2N-1:0]        w_lo_mask;
    logic [LOG2N-1:0]        w_addr_a;
    logic [LOG2N-1:0]        w_addr_b;
    logic [SW-1:0]           w_shamt;
    logic [LOG2N-2:0]        w_tw_idx;

    logic signed [OW-1:0]    w_a_r, w_a_i, w_b_r, w_b_i;
    logic signed [TW:0]      w_wr_e, w_wi_e, w_wi_c;
    logic signed [PW-1:0]    w_br_x, w_bi_x, w_wr_x, w_wi_x;
    logic signed [PW-1:0]    w_pr, w_pi;
    logic signed [OW-1:0]    w_t_r, w_t_i;
    logic signed [OW-1:0]    w_in_r_ext, w_in_i_ext;
    logic                    w_unused;

    always_comb begin
        w_j       = {1'b0, r_bf};
        w_lo_mask = (LOG2N'(1) << r_stage) - LOG2N'(1);
        w_addr_a  = ((w_j & ~w_lo_mask) << 1) | (w_j & w_lo_mask);
        w_addr_b  = w_addr_a | (LOG2N'(1) << r_stage);
        w_shamt   = SW'(LOG2N - 1) - r_stage;
        w_tw_idx  = (r_bf & w_lo_mask[LOG2N-2:0]) << w_shamt;
    end

    assign w_a_r  = r_buf_r[w_addr_a];
    assign w_a_i  = r_buf_i[w_addr_a];
    assign w_b_r  = r_buf_r[w_addr_b];
    assign w_b_i  = r_buf_i[w_addr_b];

    // One extra bit so negating the most negative twiddle cannot overflow.
    assign w_wr_e = r_tw_r[w_tw_idx];
    assign w_wi_e = r_tw_i[w_tw_idx];
    assign w_wi_c = r_inv ? -w_wi_e : w_wi_e;

    assign w_br_x = w_b_r;
    assign w_bi_x = w_b_i;
    assign w_wr_x = w_wr_e;
    assign w_wi_x = w_wi_c;

    assign w_pr   = w_br_x * w_wr_x - w_bi_x * w_wi_x;
    assign w_pi   = w_br_x * w_wi_x + w_bi_x * w_wr_x;

    // Floor shift by TW-2 followed by truncation to OW is a plain bit slice.
    assign w_t_r  = w_pr[OW+TW-3:TW-2];
    assign w_t_i  = w_pi[OW+TW-3:TW-2];

    assign w_in_r_ext = in_r;
    assign w_in_i_ext = in_i;

    assign w_unused = ^{w_pr[PW-1:OW+TW-2], w_pr[TW-3:0],
                        w_pi[PW-1:OW+TW-2], w_pi[TW-3:0], w_lo_mask[LOG2N-1]};

    // Control FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_bf        <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == '0) begin
                            r_inv <= inv;
                        end
                        if (r_cnt == '1) begin
                            r_state <= S_CALC;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CALC: begin
                    r_bf <= r_bf + 1'b1;
                    if (r_bf == '1) begin
                        if (r_stage == SW'(LOG2N - 1)) begin
                            r_stage     <= '0;
                            r_state     <= S_UNLOAD;
                            r_out_valid <= 1'b1;
                            r_out_idx   <= '0;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        r_out_idx <= r_out_idx + 1'b1;
                        if (r_out_idx == '1) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Sample/twiddle storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid) begin
            r_buf_r[bitrev(r_cnt)] <= w_in_r_ext;
            r_buf_i[bitrev(r_cnt)] <= w_in_i_ext;
            if (!r_cnt[LOG2N-1]) begin
                r_tw_r[r_cnt[LOG2N-2:0]] <= tw_r;
                r_tw_i[r_cnt[LOG2N-2:0]] <= tw_i;
            end
        end else if (r_state == S_CALC) begin
            r_buf_r[w_addr_a] <= w_a_r + w_t_r;
            r_buf_i[w_addr_a] <= w_a_i + w_t_i;
            r_buf_r[w_addr_b] <= w_a_r - w_t_r;
            r_buf_i[w_addr_b] <= w_a_i - w_t_i;
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign state     = r_state;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_valid && (r_out_idx == '1);
    assign done      = r_done;
    // The buffer is static during UNLOAD, so the bin follows the registered index.
    assign out_r     = r_out_valid ? r_buf_r[r_out_idx] : '0;
    assign out_i     = r_out_valid ? r_buf_i[r_out_idx] : '0;

endmodule

// File: tb/tb_fft_core_param.sv
// tb_fft_core_param -- directed self-checking bench for fft_core_param
// (N = 8, DW = 8, TW = 10). Expected bins are queued when a frame is driven
// and popped as the core emits them.
module tb_fft_core_param;

    localparam int LOG2N = 3;
    localparam int DW    = 8;
    localparam int TW    = 10;
    localparam int OW    = DW + 2 * LOG2N;
    localparam int N     = 1 << LOG2N;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  in_r, in_i;
    logic signed [TW-1:0]  tw_r, tw_i;
    logic                  inv;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [OW-1:0]  out_r, out_i;
    logic [LOG2N-1:0]      out_idx;
    logic                  out_last;
    logic [1:0]            state;
    logic                  done;

    fft_core_param #(.LOG2N(LOG2N), .DW(DW), .TW(TW), .OW(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .tw_r(tw_r), .tw_i(tw_i), .inv(inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last),
        .state(state), .done(done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    logic [2*OW-1:0] exp_q[$];
    int              tol_q[$];
    int xr[N], xi[N];
    int er[N], ei[N];
    int etol;
    int twr[4] = '{256, 181, 0, -181};
    int twi[4] = '{0, -181, -256, -181};

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] expv, input int tol);
        logic ok;
        ok = ((obs - expv) <= tol) && ((expv - obs) <= tol);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < N; k++) begin
            xr[k] = 0; xi[k] = 0; er[k] = 0; ei[k] = 0;
        end
        etol = 0;
    endtask

    // Driver: one frame of N beats; expectations are queued as it is driven.
    task automatic send_frame(input logic inv_v, input logic keep_valid);
        int wait_cnt;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back({OW'(er[k]), OW'(ei[k])});
            tol_q.push_back(etol);
        end
        for (int n = 0; n < N; n++) begin
            in_valid = 1'b1;
            in_r     = DW'(xr[n]);
            in_i     = DW'(xi[n]);
            tw_r     = (n < 4) ? TW'(twr[n]) : TW'($urandom);
            tw_i     = (n < 4) ? TW'(twi[n]) : TW'($urandom);
            inv      = (n == 0) ? inv_v : 1'($urandom_range(0, 1));
            wait_cnt = 0;
            while (in_ready !== 1'b1 && wait_cnt < 100) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (wait_cnt >= 100) check("in_ready_timeout", 32'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = keep_valid;
        in_r     = DW'($urandom);
        in_i     = DW'($urandom);
    endtask

    task automatic run_calc();
        int cnt;
        cnt = 0;
        while (state === 2'd1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("calc_cycles", cnt, 12);
        check("unload_state", 32'(state), 2);
        check("first_out_valid", 32'(out_valid), 1);
    endtask

    // Scoreboard side: pop and compare each bin on its handshake.
    task automatic collect_frame(input logic bp);
        int c, k, guard, tol;
        logic have_hold;
        logic signed [OW-1:0] hold_r, hold_i;
        logic [LOG2N-1:0]     hold_idx;
        logic [2*OW-1:0]      e;
        c = 0; k = 0; guard = 0; have_hold = 1'b0;
        hold_r = '0; hold_i = '0; hold_idx = '0;
        while (k < N && guard < 200) begin
            if (have_hold) begin
                check("stall_hold_r", $signed(out_r), $signed(hold_r));
                check("stall_hold_i", $signed(out_i), $signed(hold_i));
                check("stall_hold_idx", 32'(out_idx), 32'(hold_idx));
                have_hold = 1'b0;
            end
            out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (bp) check("in_ready_busy", 32'(in_ready), 0);
            check("out_valid_on", 32'(out_valid), 1);
            if (out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("queue_empty", exp_q.size(), 1);
                end else begin
                    e   = exp_q.pop_front();
                    tol = tol_q.pop_front();
                    if (tol == 0) begin
                        check($sformatf("bin%0d_r", k), $signed(out_r), $signed(e[2*OW-1:OW]));
                        check($sformatf("bin%0d_i", k), $signed(out_i), $signed(e[OW-1:0]));
                    end else begin
                        check_near($sformatf("bin%0d_r", k), $signed(out_r), $signed(e[2*OW-1:OW]), tol);
                        check_near($sformatf("bin%0d_i", k), $signed(out_i), $signed(e[OW-1:0]), tol);
                    end
                end
                check("out_idx", 32'(out_idx), k);
                check("out_last", 32'(out_last), 32'(k == N - 1));
                k++;
            end else if (out_valid === 1'b1) begin
                have_hold = 1'b1;
                hold_r    = out_r;
                hold_i    = out_i;
                hold_idx  = out_idx;
            end
            c++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("unload_timeout", k, N);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_pulse", 32'(done), 1);
        check("post_state", 32'(state), 0);
        check("post_in_ready", 32'(in_ready), 1);
        check("post_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("done_clear", 32'(done), 0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_r = '0; in_i = '0; tw_r = '0; tw_i = '0; inv = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_out_r", $signed(out_r), 0);
        check("rst_out_i", $signed(out_i), 0);
        rst = 1'b1;
        @(negedge clk);

        // Impulse
        clear_frame();
        xr[0] = 100;
        for (int k = 0; k < N; k++) er[k] = 100;
        send_frame(1'b0, 1'b0);
        run_calc();
        collect_frame(1'b0);

        // DC
        clear_frame();
        for (int k = 0; k < N; k++) xr[k] = 10;
        er[0] = 80;
        send_frame(1'b0, 1'b0);
        run_calc();
        collect_frame(1'b0);

        // Alternating, forward then inverse
        clear_frame();
        for (int k = 0; k < N; k++) xr[k] = (k % 2 == 0) ? 50 : -50;
        er[4] = 400;
        send_frame(1'b0, 1'b0);
        run_calc();
        collect_frame(1'b0);
        send_frame(1'b1, 1'b0);
        run_calc();
        collect_frame(1'b0);

        // Complex tone 100*exp(+j*2*pi*n/8)
        clear_frame();
        xr = '{100, 71, 0, -71, -100, -71, 0, 71};
        xi = '{0, 71, 100, 71, 0, -71, -100, -71};
        etol  = 8;
        er[1] = 800;
        send_frame(1'b0, 1'b0);
        run_calc();
        collect_frame(1'b0);
        er[1] = 0;
        er[7] = 800;
        send_frame(1'b1, 1'b0);
        run_calc();
        collect_frame(1'b0);

        // Backpressure with in_valid held high
        clear_frame();
        for (int k = 0; k < N; k++) xr[k] = (k % 2 == 0) ? 50 : -50;
        er[4] = 400;
        send_frame(1'b0, 1'b1);
        run_calc();
        collect_frame(1'b1);

        // Reset pulse in the middle of CALC
        clear_frame();
        xr[0] = 100;
        send_frame(1'b0, 1'b0);
        exp_q.delete();
        tol_q.delete();
        repeat (3) @(negedge clk);
        check("mid_calc_state", 32'(state), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_state", 32'(state), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        for (int k = 0; k < N; k++) er[k] = 100;
        send_frame(1'b0, 1'b0);
        run_calc();
        collect_frame(1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
